// File: rtl/argmax_dual_serial.sv
// Two-channel-per-clock signed argmax over a packed channel vector.
// One-deep pending slot absorbs a vector arriving mid-scan; a second one is dropped and flagged.
module argmax_dual_serial #(
    parameter int DATA_WIDTH  = 8,
    parameter int OUT_CHANNEL = 17
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [DATA_WIDTH*OUT_CHANNEL-1:0] i_data,
    input  logic                              i_valid,
    output logic [$clog2(OUT_CHANNEL)-1:0]    o_idx,
    output logic [DATA_WIDTH-1:0]             o_max,
    output logic                              o_valid,
    output logic                              o_busy,
    output logic                              o_overflow
);

    localparam int STEPS  = (OUT_CHANNEL + 1) / 2;
    localparam int IDX_W  = $clog2(OUT_CHANNEL);
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int VEC_W  = DATA_WIDTH * OUT_CHANNEL;
    localparam int PAD_W  = DATA_WIDTH * 2 * STEPS;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic              ODD_TAIL  = 1'((OUT_CHANNEL % 2) == 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    state_t                  state_r, state_nx_s;
    logic [STEP_W-1:0]       step_r, step_nx_s;
    logic [VEC_W-1:0]        work_r, work_nx_s;
    logic [VEC_W-1:0]        pend_data_r, pend_data_nx_s;
    logic                    pend_r, pend_nx_s;
    logic                    ovf_r, ovf_nx_s;
    logic signed [DATA_WIDTH-1:0] best_val_r, best_val_nx_s;
    logic [IDX_W-1:0]        best_idx_r, best_idx_nx_s;
    logic                    valid_r, valid_nx_s;
    logic [IDX_W-1:0]        o_idx_r, o_idx_nx_s;
    logic [DATA_WIDTH-1:0]   o_max_r, o_max_nx_s;

    logic [PAD_W-1:0]              work_pad_s;
    logic signed [DATA_WIDTH-1:0]  ch_s [2*STEPS];
    logic signed [DATA_WIDTH-1:0]  ch_a_s, ch_b_s;
    logic                          b_live_s;
    logic signed [DATA_WIDTH-1:0]  pair_val_s, cand_val_s;
    logic [IDX_W-1:0]              pair_idx_s, cand_idx_s;
    logic                          last_s;

    // Split the work vector into channels, padding to a whole number of pairs.
    always_comb begin
        work_pad_s = {PAD_W{1'b0}};
        work_pad_s[VEC_W-1:0] = work_r;
        for (int c = 0; c < 2*STEPS; c++) begin
            ch_s[c] = work_pad_s[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Pair winner for this step, then merge with the running best (lower index wins ties).
    always_comb begin
        ch_a_s   = ch_s[{step_r, 1'b0}];
        ch_b_s   = ch_s[{step_r, 1'b1}];
        last_s   = (step_r == LAST_STEP);
        b_live_s = !(ODD_TAIL && last_s);
        if (b_live_s && (ch_b_s > ch_a_s)) begin
            pair_val_s = ch_b_s;
            pair_idx_s = IDX_W'({step_r, 1'b1});
        end else begin
            pair_val_s = ch_a_s;
            pair_idx_s = IDX_W'({step_r, 1'b0});
        end
        if ((step_r == {STEP_W{1'b0}}) || (pair_val_s > best_val_r)) begin
            cand_val_s = pair_val_s;
            cand_idx_s = pair_idx_s;
        end else begin
            cand_val_s = best_val_r;
            cand_idx_s = best_idx_r;
        end
    end

    // Next-state and register-update logic for the scan controller.
    always_comb begin
        state_nx_s     = state_r;
        step_nx_s      = step_r;
        work_nx_s      = work_r;
        pend_data_nx_s = pend_data_r;
        pend_nx_s      = pend_r;
        ovf_nx_s       = ovf_r;
        best_val_nx_s  = best_val_r;
        best_idx_nx_s  = best_idx_r;
        valid_nx_s     = 1'b0;
        o_idx_nx_s     = o_idx_r;
        o_max_nx_s     = o_max_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    work_nx_s  = i_data;
                    step_nx_s  = {STEP_W{1'b0}};
                    state_nx_s = ST_SCAN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                best_val_nx_s = cand_val_s;
                best_idx_nx_s = cand_idx_s;
                if (last_s) begin
                    valid_nx_s = 1'b1;
                    o_idx_nx_s = cand_idx_s;
                    o_max_nx_s = cand_val_s;
                    step_nx_s  = {STEP_W{1'b0}};
                    if (pend_r) begin
                        work_nx_s = pend_data_r;
                        if (i_valid) begin
                            pend_data_nx_s = i_data;
                        end else begin
                            pend_nx_s = 1'b0;
                        end
                    end else if (i_valid) begin
                        work_nx_s = i_data;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end else begin
                    step_nx_s = step_r + STEP_W'(1);
                    if (i_valid && !pend_r) begin
                        pend_data_nx_s = i_data;
                        pend_nx_s      = 1'b1;
                    end else if (i_valid) begin
                        ovf_nx_s = 1'b1;
                    end else begin
                        pend_nx_s = pend_r;
                    end
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any scan in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            step_r      <= {STEP_W{1'b0}};
            work_r      <= {VEC_W{1'b0}};
            pend_data_r <= {VEC_W{1'b0}};
            pend_r      <= 1'b0;
            ovf_r       <= 1'b0;
            best_val_r  <= {DATA_WIDTH{1'b0}};
            best_idx_r  <= {IDX_W{1'b0}};
            valid_r     <= 1'b0;
            o_idx_r     <= {IDX_W{1'b0}};
            o_max_r     <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            step_r      <= step_nx_s;
            work_r      <= work_nx_s;
            pend_data_r <= pend_data_nx_s;
            pend_r      <= pend_nx_s;
            ovf_r       <= ovf_nx_s;
            best_val_r  <= best_val_nx_s;
            best_idx_r  <= best_idx_nx_s;
            valid_r     <= valid_nx_s;
            o_idx_r     <= o_idx_nx_s;
            o_max_r     <= o_max_nx_s;
        end
    end

    assign o_idx      = o_idx_r;
    assign o_max      = o_max_r;
    assign o_valid    = valid_r;
    assign o_busy     = (state_r == ST_SCAN);
    assign o_overflow = ovf_r;

endmodule

// File: tb/tb_argmax_dual_serial.sv
// Directed bench for argmax_dual_serial (8-bit, 17 channels): each scenario task
// drives a per-cycle stimulus table and checks the recorded result pulses inline.
module tb_argmax_dual_serial;

    localparam int DW = 8;
    localparam int OC = 17;
    localparam int IW = 5;
    localparam int NMAX = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [DW*OC-1:0] i_data = '0;
    logic             i_valid = 1'b0;
    logic [IW-1:0]    o_idx;
    logic [DW-1:0]    o_max;
    logic             o_valid;
    logic             o_busy;
    logic             o_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DW*OC-1:0] stim_d [NMAX];
    logic             stim_v [NMAX];
    logic             stim_rst [NMAX];
    logic             ovf_log [NMAX];
    logic             busy_log [NMAX];
    int               pc [$];
    logic [IW-1:0]    pi [$];
    logic [DW-1:0]    pm [$];

    argmax_dual_serial #(.DATA_WIDTH(DW), .OUT_CHANNEL(OC)) dut (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_idx(o_idx), .o_max(o_max), .o_valid(o_valid), .o_busy(o_busy),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [DW*OC-1:0] fill_vec(input logic [DW-1:0] f);
        logic [DW*OC-1:0] v;
        for (int c = 0; c < OC; c++) v[c*DW +: DW] = f;
        return v;
    endfunction

    task automatic clear_stim();
        for (int k = 0; k < NMAX; k++) begin
            stim_d[k] = '0;
            stim_v[k] = 1'b0;
            stim_rst[k] = 1'b1;
        end
        pc.delete();
        pi.delete();
        pm.delete();
    endtask

    // Cycle k starts #1 after the k-th edge: sample outputs, then drive inputs for cycle k.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ovf_log[k] = o_overflow;
            busy_log[k] = o_busy;
            if (o_valid) begin
                pc.push_back(k);
                pi.push_back(o_idx);
                pm.push_back(o_max);
            end
            rst_n = stim_rst[k];
            i_valid = stim_v[k];
            i_data = stim_d[k];
        end
        i_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({o_valid, o_busy, o_overflow} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000", {o_valid, o_busy, o_overflow});
        end
        tests_run++;
        if (o_idx !== 5'd0 || o_max !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got idx %0d max %0d expected 0 0", o_idx, o_max);
        end
        rst_n = 1'b1;
        clear_stim();
        run(20);
        tests_run++;
        if (pc.size() != 0) begin
            tests_failed++;
            $display("FAIL reset_idle_pulses: got %0d expected 0", pc.size());
        end
        tests_run++;
        if ({o_busy, o_overflow, o_idx, o_max} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_idle_outputs: got %h expected 0", {o_busy, o_overflow, o_idx, o_max});
        end
    endtask

    task automatic test_single();
        logic [DW*OC-1:0] v;
        clear_stim();
        v = '0;
        v[5*DW +: DW] = 8'd100;
        v[12*DW +: DW] = 8'hFD;
        stim_d[0] = v;
        stim_v[0] = 1'b1;
        run(16);
        tests_run++;
        if (pc.size() != 1 || (pc.size() == 1 && pc[0] != 10)) begin
            tests_failed++;
            $display("FAIL single_timing: got %0d pulses first at %0d expected 1 at 10",
                     pc.size(), (pc.size() > 0) ? pc[0] : -1);
        end
        tests_run++;
        if (pc.size() < 1 || pi[0] !== 5'd5 || pm[0] !== 8'd100) begin
            tests_failed++;
            $display("FAIL single_result: got idx %0d max %0d expected 5 100",
                     (pi.size() > 0) ? pi[0] : 5'd0, (pm.size() > 0) ? pm[0] : 8'd0);
        end
        tests_run++;
        if (busy_log[5] !== 1'b1 || busy_log[12] !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy: got c5=%b c12=%b expected 1 0", busy_log[5], busy_log[12]);
        end
        tests_run++;
        if (o_idx !== 5'd5 || o_max !== 8'd100) begin
            tests_failed++;
            $display("FAIL single_hold: got idx %0d max %0d expected 5 100", o_idx, o_max);
        end
    endtask

    task automatic test_ties_signed();
        logic [DW*OC-1:0] v [3];
        logic [IW-1:0]    ei [3];
        logic [DW-1:0]    em [3];
        v[0] = fill_vec(8'h80);
        v[0][3*DW +: DW] = 8'h7F;
        v[0][4*DW +: DW] = 8'h7F;
        v[0][16*DW +: DW] = 8'h7F;
        ei[0] = 5'd3;  em[0] = 8'h7F;
        v[1] = fill_vec(8'hFF);
        ei[1] = 5'd0;  em[1] = 8'hFF;
        v[2] = fill_vec(8'h80);
        v[2][16*DW +: DW] = 8'h01;
        ei[2] = 5'd16; em[2] = 8'h01;
        for (int t = 0; t < 3; t++) begin
            clear_stim();
            stim_d[0] = v[t];
            stim_v[0] = 1'b1;
            run(14);
            tests_run++;
            if (pc.size() != 1 || pc[0] != 10 || pi[0] !== ei[t] || pm[0] !== em[t]) begin
                tests_failed++;
                $display("FAIL ties_signed_%0d: got %0d pulses idx %0d max %h expected 1 pulse at 10 idx %0d max %h",
                         t, pc.size(), (pi.size() > 0) ? pi[0] : 5'd0,
                         (pm.size() > 0) ? pm[0] : 8'd0, ei[t], em[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int            ec [3];
        logic [IW-1:0] ei [3];
        clear_stim();
        ec = '{10, 19, 28};
        ei = '{5'd0, 5'd8, 5'd16};
        for (int t = 0; t < 3; t++) begin
            stim_d[9*t] = fill_vec(8'hF0);
            stim_d[9*t][ei[t]*DW +: DW] = 8'd50 + 8'(t);
            stim_v[9*t] = 1'b1;
        end
        run(34);
        tests_run++;
        if (pc.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d expected 3", pc.size());
        end
        for (int t = 0; t < 3; t++) begin
            tests_run++;
            if (t >= pc.size() || pc[t] != ec[t] || pi[t] !== ei[t] || pm[t] !== 8'd50 + 8'(t)) begin
                tests_failed++;
                $display("FAIL b2b_result_%0d: got cycle %0d idx %0d expected cycle %0d idx %0d",
                         t, (t < pc.size()) ? pc[t] : -1, (t < pi.size()) ? pi[t] : 5'd0, ec[t], ei[t]);
            end
        end
        tests_run++;
        if (o_overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_overflow: got %b expected 0", o_overflow);
        end
    endtask

    task automatic test_burst_overflow();
        clear_stim();
        for (int t = 0; t < 3; t++) begin
            stim_d[t] = fill_vec(8'h00);
            stim_d[t][(t+1)*DW +: DW] = 8'd9;
            stim_v[t] = 1'b1;
        end
        run(30);
        tests_run++;
        if (pc.size() != 2 || pc[0] != 10 || pc[1] != 19 || pi[0] !== 5'd1 || pi[1] !== 5'd2) begin
            tests_failed++;
            $display("FAIL burst_results: got %0d pulses idx %0d/%0d expected 2 pulses idx 1@10 2@19",
                     pc.size(), (pi.size() > 0) ? pi[0] : 5'd0, (pi.size() > 1) ? pi[1] : 5'd0);
        end
        tests_run++;
        if (ovf_log[2] !== 1'b0 || ovf_log[3] !== 1'b1 || ovf_log[29] !== 1'b1) begin
            tests_failed++;
            $display("FAIL burst_overflow: got c2=%b c3=%b c29=%b expected 0 1 1",
                     ovf_log[2], ovf_log[3], ovf_log[29]);
        end
    endtask

    task automatic test_reset_mid_scan();
        clear_stim();
        stim_d[0] = fill_vec(8'h00);
        stim_d[0][2*DW +: DW] = 8'd77;
        stim_v[0] = 1'b1;
        stim_rst[5] = 1'b0;
        stim_rst[6] = 1'b0;
        stim_d[10] = fill_vec(8'hC0);
        stim_d[10][7*DW +: DW] = 8'd33;
        stim_v[10] = 1'b1;
        run(26);
        tests_run++;
        if (busy_log[6] !== 1'b0 || ovf_log[6] !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_clear: got busy %b ovf %b expected 0 0", busy_log[6], ovf_log[6]);
        end
        tests_run++;
        if (pc.size() != 1 || pc[0] != 20 || pi[0] !== 5'd7 || pm[0] !== 8'd33) begin
            tests_failed++;
            $display("FAIL midrst_result: got %0d pulses first at %0d idx %0d expected 1 at 20 idx 7",
                     pc.size(), (pc.size() > 0) ? pc[0] : -1, (pi.size() > 0) ? pi[0] : 5'd0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_ties_signed();
        test_back_to_back();
        test_burst_overflow();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
